// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, data width and default bit timing.
package uart_pkg;

    // Frame FSM encoding, shared by the transmitter and the receiver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter. Push is ignored when full and
// pop is ignored when empty, so the count can never over- or underflow.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first. Bytes queue in a small FIFO and
// are serialized back-to-back with no idle gap while data remains queued.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for CLK_DIV cycles
//   ST_DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   ST_STOP  | stop bit (high); on its tick chain straight into the next byte
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [UART_DATA_BITS-1:0]     tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [15:0] TICK_CNT = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic                      tx_q, tx_d;
    logic [15:0]               clk_cnt_q, clk_cnt_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shifter_q, shifter_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic                      tick;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign tick      = (clk_cnt_q == TICK_CNT);
    assign tx        = tx_q;
    assign tx_busy   = (state_q != ST_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing: bit timer, bit counter, shifter and next line level.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shifter_d = shifter_q;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shifter_d = fifo_rd_data;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    clk_cnt_d = '0;
                    tx_d      = shifter_q[0];
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    clk_cnt_d = '0;
                    shifter_d = shifter_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // The bit about to become shifter[0] after this shift.
                        tx_d      = shifter_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    clk_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shifter_d = fifo_rd_data;
                        tx_d      = 1'b0;
                        state_d   = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_d      = 1'b1;
                clk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Frame FSM registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shifter_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shifter_q <= shifter_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int cmp_cnt = 0;
    int err_cnt = 0;

    uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for each of the 40 cycles of one frame.
    function automatic logic [39:0] frame_bits(input logic [7:0] d);
        logic [39:0] f;
        int b;
        for (int i = 0; i < 40; i++) begin
            b = i / CLK_DIV;
            f[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
        end
        return f;
    endfunction

    // Sample tx/tx_busy now and on the next n-1 falling edges.
    task automatic cap(input int n, output logic [255:0] bits, output int busy_n);
        bits   = '0;
        busy_n = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bits[i] = tx;
            if (tx_busy) busy_n++;
        end
    endtask

    logic [255:0] bits;
    logic [255:0] cap3;
    logic [255:0] exp3;
    int           busy_n;
    int           idx;
    int           n_acc;
    int           acc6;
    int           low_cnt;
    logic         acc;

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_count", fifo_count, 3'd0);
        rst_n = 1'b1;

        // 1. Single byte 0xA5
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("s1_count_after_accept", fifo_count, 3'd1);
        chk("s1_tx_not_yet_low", tx, 1'b1);
        chk("s1_busy_not_yet", tx_busy, 1'b0);
        @(negedge clk);
        cap(40, bits, busy_n);
        chk("s1_line", bits[39:0], frame_bits(8'hA5));
        chk("s1_busy_cycles", busy_n, 40);
        @(negedge clk);
        chk("s1_busy_end", tx_busy, 1'b0);
        chk("s1_tx_idle", tx, 1'b1);

        // 2. Back-to-back 0x00 then 0xFF
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        cap(80, bits, busy_n);
        chk("s2_line", bits[79:0], {frame_bits(8'hFF), frame_bits(8'h00)});
        chk("s2_busy_cycles", busy_n, 80);
        @(negedge clk);
        chk("s2_busy_end", tx_busy, 1'b0);

        // 3. Full FIFO: hold valid with 0x01..0x06
        idx      = 1;
        n_acc    = 0;
        acc6     = -1;
        cap3     = '0;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        for (int c = 0; c <= 240; c++) begin
            acc = tx_valid && tx_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                n_acc++;
                if (idx == 6) begin
                    acc6     = c;
                    tx_valid = 1'b0;
                end else begin
                    idx++;
                    tx_data = 8'(idx);
                end
            end
            if (c == 4) begin
                chk("s3_accepted_by_edge4", n_acc, 5);
                chk("s3_ready_low_full", tx_ready, 1'b0);
                chk("s3_count_full", fifo_count, 3'd4);
            end
            if (c >= 1) cap3[c-1] = tx;
        end
        exp3 = '0;
        for (int i = 0; i < 6; i++) exp3[i*40 +: 40] = frame_bits(8'(i + 1));
        chk("s3_byte6_accept_edge", acc6, 42);
        chk("s3_total_accepted", n_acc, 6);
        chk("s3_line", cap3[239:0], exp3[239:0]);
        @(negedge clk);
        chk("s3_busy_end", tx_busy, 1'b0);

        // 4. Simultaneous push and pop on the STOP tick
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h22;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h33;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("s4_count_two", fifo_count, 3'd2);
        repeat (38) @(negedge clk);
        chk("s4_in_stop", tx, 1'b1);
        chk("s4_count_before", fifo_count, 3'd2);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("s4_count_same", fifo_count, 3'd2);
        chk("s4_no_gap_start", tx, 1'b0);
        cap(120, bits, busy_n);
        chk("s4_line", bits[119:0], {frame_bits(8'h3C), frame_bits(8'h33), frame_bits(8'h22)});
        chk("s4_busy_cycles", busy_n, 120);
        @(negedge clk);
        chk("s4_busy_end", tx_busy, 1'b0);

        // 5. Reset during data bit 3 with 2 bytes queued
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h6B;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h7C;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("s5_count_two", fifo_count, 3'd2);
        repeat (15) @(negedge clk);
        chk("s5_busy_before_rst", tx_busy, 1'b1);
        chk("s5_data_bit3", tx, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5_rst_tx", tx, 1'b1);
        chk("s5_rst_busy", tx_busy, 1'b0);
        chk("s5_rst_count", fifo_count, 3'd0);
        chk("s5_rst_ready", tx_ready, 1'b1);
        low_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (!tx || tx_busy) low_cnt++;
        end
        chk("s5_no_frame_after_rst", low_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
